stream_shell_mc: RTL and testbench

//  Multi-channel successor to the single-channel stream shell: NUM_CH independent input streams, each buffered
//  in its own FIFO, merged round-robin onto one registered valid/ready output that carries the source channel id.

---
 rtl/stream_pkg.sv | 14 +
 rtl/stream_fifo_ch.sv | 76 +++++++
 rtl/stream_shell_mc.sv | 112 +++++++++++
 tb/tb_stream_shell_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared defaults and helpers for the multi-channel stream shell.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_pkg;

    localparam int DEF_PAYLOAD_BITS       = 32;
    localparam int DEF_NUM_BRAM_ADDR_BITS = 7;

    // Width of a channel id; a single channel still gets one bit so ports never collapse to zero width.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_fifo_ch.sv
// Per-channel show-ahead FIFO with inferred RAM, occupancy count and registered almost-full flag.
// Latency: a word written at edge E appears on o_head / clears o_empty after E (visible next cycle).
// Backpressure: pushes while full and pops while empty are ignored; o_full is from the registered count only.
// Ports: i_push/i_dat write side, i_pop read side, o_head current head word,
//        o_full/o_empty status from the registered count, o_afull registered threshold flag.
module stream_fifo_ch
    import stream_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int ADDR_BITS    = DEF_NUM_BRAM_ADDR_BITS,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [PAYLOAD_BITS-1:0] i_dat,
    input  logic                    i_pop,
    output logic [PAYLOAD_BITS-1:0] o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_afull
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CNT_W = ADDR_BITS + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_TH = CNT_W'(DEPTH - AFULL_MARGIN);

    logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0]    r_wr_ptr;
    logic [ADDR_BITS-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;
    logic                    r_afull;
    logic                    w_push;
    logic                    w_pop;

    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_afull = r_afull;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_afull  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
            r_count <= w_count_nxt;
            // Registered from the next-state count so the flag lines up with the occupancy it describes.
            r_afull <= (w_count_nxt >= AFULL_TH);
        end
    end

endmodule

// File: rtl/stream_shell_mc.sv
// NUM_CH buffered input streams merged round-robin onto one registered valid/ready output tagged with channel id.
// Latency: val_in cycle to val_out is 2 edges; one word per cycle aggregate under continuous ready_downward.
// Backpressure: output holds while val_out && !ready_downward; per-channel ready_upward drops when its FIFO is full.
// Ports: din/val_in/ready_upward per-channel write side; almost_full/overflow per-channel status;
//        dout/dout_ch/val_out/ready_downward merged output link.
module stream_shell_mc
    import stream_pkg::*;
#(
    parameter int PAYLOAD_BITS       = DEF_PAYLOAD_BITS,
    parameter int NUM_BRAM_ADDR_BITS = DEF_NUM_BRAM_ADDR_BITS,
    parameter int NUM_CH             = 4,
    parameter int AFULL_MARGIN       = 4,
    localparam int CH_BITS           = clog2_min1(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH*PAYLOAD_BITS-1:0] din,
    input  logic [NUM_CH-1:0]              val_in,
    output logic [NUM_CH-1:0]              ready_upward,
    output logic [NUM_CH-1:0]              almost_full,
    output logic [NUM_CH-1:0]              overflow,
    output logic [PAYLOAD_BITS-1:0]        dout,
    output logic [CH_BITS-1:0]             dout_ch,
    output logic                           val_out,
    input  logic                           ready_downward
);

    logic [PAYLOAD_BITS-1:0] w_head [NUM_CH];
    logic [NUM_CH-1:0]       w_full;
    logic [NUM_CH-1:0]       w_empty;
    logic [NUM_CH-1:0]       w_push;
    logic [NUM_CH-1:0]       w_pop;
    logic [NUM_CH-1:0]       r_overflow;
    logic [PAYLOAD_BITS-1:0] r_dout;
    logic [CH_BITS-1:0]      r_dout_ch;
    logic                    r_val_out;
    logic [CH_BITS-1:0]      r_rr;
    logic [CH_BITS-1:0]      w_grant;
    logic [CH_BITS-1:0]      w_idx;
    logic                    w_any;
    logic                    w_load;

    // Gated by reset so the upstream sees no space while the shell is held in reset.
    assign ready_upward = {NUM_CH{reset}} & ~w_full;
    assign w_push       = val_in & ready_upward;
    assign w_load       = !r_val_out || ready_downward;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_pop[g] = w_load && w_any && (w_grant == CH_BITS'(g));

            stream_fifo_ch #(
                .PAYLOAD_BITS (PAYLOAD_BITS),
                .ADDR_BITS    (NUM_BRAM_ADDR_BITS),
                .AFULL_MARGIN (AFULL_MARGIN)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (reset),
                .i_push  (w_push[g]),
                .i_dat   (din[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .i_pop   (w_pop[g]),
                .o_head  (w_head[g]),
                .o_full  (w_full[g]),
                .o_empty (w_empty[g]),
                .o_afull (almost_full[g])
            );
        end
    endgenerate

    // Search starts one past the last grant, so the most recently served channel has lowest priority.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = CH_BITS'((int'(r_rr) + i) % NUM_CH);
            if (!w_any && !w_empty[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout     <= '0;
            r_dout_ch  <= '0;
            r_val_out  <= 1'b0;
            r_rr       <= CH_BITS'(NUM_CH - 1);
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | (val_in & ~ready_upward);
            if (w_load) begin
                if (w_any) begin
                    r_dout    <= w_head[w_grant];
                    r_dout_ch <= w_grant;
                    r_val_out <= 1'b1;
                    r_rr      <= w_grant;
                end else begin
                    r_val_out <= 1'b0;
                end
            end
        end
    end

    assign dout     = r_dout;
    assign dout_ch  = r_dout_ch;
    assign val_out  = r_val_out;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_stream_shell_mc.sv
module tb_stream_shell_mc;

    localparam int NCH = 4;
    localparam int PW  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH*PW-1:0] din = '0;
    logic [NCH-1:0]    val_in = '0;
    logic [NCH-1:0]    ready_upward;
    logic [NCH-1:0]    almost_full;
    logic [NCH-1:0]    overflow;
    logic [PW-1:0]     dout;
    logic [1:0]        dout_ch;
    logic              val_out;
    logic              ready_downward = 1'b0;

    stream_shell_mc dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .val_in         (val_in),
        .ready_upward   (ready_upward),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .dout           (dout),
        .dout_ch        (dout_ch),
        .val_out        (val_out),
        .ready_downward (ready_downward)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [PW-1:0] exp_q [NCH][$];
    int          obs_ch[$];
    int          obs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted output word must be the oldest outstanding word of its channel.
    always @(negedge clk) begin
        if (reset && val_out && ready_downward) begin
            logic [PW-1:0] e;
            obs_ch.push_back(int'(dout_ch));
            obs_cyc.push_back(cyc);
            if (exp_q[dout_ch].size() == 0) begin
                chk("spurious_out", 64'(dout_ch) + 64'd1, 64'd0);
            end else begin
                e = exp_q[dout_ch].pop_front();
                chk("out_data", dout, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
    endtask

    task automatic push(input logic [NCH-1:0] mask, input logic [PW-1:0] base, input bit acc);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                din[c*PW +: PW] = base + PW'(c);
                if (acc) exp_q[c].push_back(base + PW'(c));
            end
        end
        val_in = mask;
        tick();
        val_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_exp();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int bound);
        int pending;
        pending = 1;
        for (int n = 0; n < bound && pending != 0; n++) begin
            pending = int'(val_out);
            for (int c = 0; c < NCH; c++) pending += exp_q[c].size();
            if (pending != 0) tick();
        end
        pending = int'(val_out);
        for (int c = 0; c < NCH; c++) pending += exp_q[c].size();
        chk("drain_pending", 64'(pending), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int vcnt;
        // Reset state
        #1;
        chk("rst_val_out", val_out, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ready_up", ready_upward, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_overflow", overflow, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_ready", ready_upward, 4'hF);

        // 1: first-word latency
        ready_downward = 1'b1;
        push(4'b0001, 32'h0000_00A5, 1'b1);
        chk("t1_val_after_1edge", val_out, 0);
        tick();
        chk("t1_val_after_2edge", val_out, 1);
        chk("t1_dout", dout, 32'hA5);
        chk("t1_dout_ch", dout_ch, 0);
        tick();
        chk("t1_val_drop", val_out, 0);

        // 2: round-robin across 4 preloaded channels
        do_reset();
        obs_ch.delete();
        obs_cyc.delete();
        ready_downward = 1'b1;
        for (int k = 0; k < 3; k++) push(4'hF, 32'h1000_0000 + PW'(k * 16), 1'b1);
        wait_drain(50);
        chk("t2_count", 64'(obs_ch.size()), 12);
        for (int i = 0; i < obs_ch.size(); i++) begin
            chk("t2_rr_ch", 64'(obs_ch[i]), 64'(i % 4));
            chk("t2_consecutive", 64'(obs_cyc[i] - obs_cyc[0]), 64'(i));
        end

        // 3: stall holds output stable
        ready_downward = 1'b0;
        push(4'hF, 32'h3000_0000, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t3_val_hold", val_out, 1);
            chk("t3_dout_hold", dout, 32'h3000_0000);
            chk("t3_ch_hold", dout_ch, 0);
            chk("t3_ready_hold", ready_upward, 4'hF);
            tick();
        end
        ready_downward = 1'b1;
        wait_drain(50);

        // 4: fill ch2 behind a stalled output word
        ready_downward = 1'b0;
        push(4'b0001, 32'h4000_0000, 1'b1);
        tick();
        chk("t4_stalled", val_out, 1);
        for (int k = 0; k < 128; k++) begin
            push(4'b0100, 32'h4100_0000 + PW'(k * 16), 1'b1);
            if (k + 1 == 123) chk("t4_afull_123", almost_full[2], 0);
            if (k + 1 == 124) chk("t4_afull_124", almost_full[2], 1);
            if (k + 1 == 127) chk("t4_ready_127", ready_upward[2], 1);
        end
        chk("t4_ready_full", ready_upward, 4'b1011);
        chk("t4_afull_full", almost_full, 4'b0100);
        chk("t4_ovf_before", overflow, 0);
        push(4'b0100, 32'h4FFF_0000, 1'b0);
        chk("t4_ovf_after", overflow, 4'b0100);
        ready_downward = 1'b1;
        wait_drain(400);
        chk("t4_ready_drained", ready_upward, 4'hF);

        // 5: simultaneous push and pop on ch1 at count 1
        ready_downward = 1'b1;
        push(4'b0010, 32'h5000_0000, 1'b1);
        chk("t5_not_yet", val_out, 0);
        push(4'b0010, 32'h5100_0000, 1'b1);
        chk("t5_val_a", val_out, 1);
        chk("t5_dout_a", dout, 32'h5000_0001);
        chk("t5_ch_a", dout_ch, 1);
        tick();
        chk("t5_val_b", val_out, 1);
        chk("t5_dout_b", dout, 32'h5100_0001);
        chk("t5_ch_b", dout_ch, 1);
        tick();
        chk("t5_val_end", val_out, 0);
        chk("t5_ovf_sticky", overflow, 4'b0100);

        // 6: async reset mid-stream
        ready_downward = 1'b0;
        for (int k = 0; k < 12; k++) push(4'hF, 32'h6000_0000 + PW'(k * 16), 1'b1);
        push(4'b0011, 32'h6100_0000, 1'b1);
        tick();
        chk("t6_busy", val_out, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_val", val_out, 0);
        chk("t6_rst_dout", dout, 0);
        chk("t6_rst_ready", ready_upward, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_afull", almost_full, 0);
        clear_exp();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("t6_ready_after", ready_upward, 4'hF);
        ready_downward = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (val_out) vcnt++;
            tick();
        end
        chk("t6_no_stale", 64'(vcnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
